bresenham_line_engine: RTL and testbench

- Parametrised successor to the fixed 9-bit line solver used for thread scoring in the string-art pipeline.
- Walks the Bresenham line between two pins in all octants and issues one pixel read per point over a valid/ready port.
- Accumulates the returned pixel values into a reduction score plus a pixel count.
- In change mode, also writes back each pixel reduced by THREAD_DELTA, saturating at 0.

---
 rtl/bresenham_line_engine.sv | 163 ++++++++++++++++
 tb/tb_bresenham_line_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_line_engine.sv
// Bresenham line walker: issues one pixel read per point, accumulates the returned
// values and optionally writes each pixel back reduced by THREAD_DELTA (floor 0).
module bresenham_line_engine #(
    parameter int COORD_W      = 9,
    parameter int PIX_W        = 8,
    parameter int IMG_W        = 512,
    parameter int ADDR_W       = 18,
    parameter int THREAD_DELTA = 32,
    parameter int SUM_W        = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [COORD_W-1:0] req_point_1_x,
    input  logic [COORD_W-1:0] req_point_1_y,
    input  logic [COORD_W-1:0] req_point_2_x,
    input  logic [COORD_W-1:0] req_point_2_y,
    input  logic               change,
    output logic               rd_val,
    input  logic               rd_rdy,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_data_val,
    input  logic [PIX_W-1:0]   rd_data,
    input  logic [ADDR_W-1:0]  rd_data_addr,
    output logic               wr_val,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIX_W-1:0]   wr_data,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [SUM_W-1:0]   reduction,
    output logic [COORD_W:0]   pix_count
);

    localparam int EW = COORD_W + 2;
    localparam int CW = COORD_W + 1;

    typedef enum logic [2:0] {IDLE, SETUP, WALK, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [COORD_W-1:0] p1x, p1y, p2x, p2y, x, y;
    logic               chg, sx_neg, sy_neg;
    logic signed [EW-1:0] dx, dy, err, err_nxt;
    logic signed [EW:0]   e2, dx_e, dy_e;
    logic               step_x, step_y, at_end;
    logic [COORD_W-1:0] adx, ady;
    logic [CW-1:0]      issued, returned;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] v);
        if (int'(v) > THREAD_DELTA)
            return v - PIX_W'(THREAD_DELTA);
        return '0;
    endfunction

    assign adx     = abs_diff(p2x, p1x);
    assign ady     = abs_diff(p2y, p1y);
    assign at_end  = (x == p2x) && (y == p2y);
    assign e2      = $signed({err, 1'b0});
    assign dx_e    = $signed({dx[EW-1], dx});
    assign dy_e    = $signed({dy[EW-1], dy});
    assign step_x  = (e2 >= dy_e);
    assign step_y  = (e2 <= dx_e);
    // Both error corrections use the pre-step err and may apply in the same cycle.
    assign err_nxt = err + (step_x ? dy : EW'(0)) + (step_y ? dx : EW'(0));
    assign rd_addr = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    assign pix_count = issued;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_val) state_nxt = SETUP;
            SETUP:   state_nxt = WALK;
            WALK:    if (rd_rdy && at_end) state_nxt = DRAIN;
            DRAIN:   if (returned == issued) state_nxt = DONE;
            DONE:    if (resp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_rdy  = (state == IDLE);
        rd_val   = (state == WALK);
        resp_val = (state == DONE);
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (req_val) begin
                    p1x <= req_point_1_x;
                    p1y <= req_point_1_y;
                    p2x <= req_point_2_x;
                    p2y <= req_point_2_y;
                    chg <= change;
                end
            end
            SETUP: begin
                dx     <= $signed({2'b00, adx});
                dy     <= -$signed({2'b00, ady});
                err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
                sx_neg <= (p2x < p1x);
                sy_neg <= (p2y < p1y);
                x      <= p1x;
                y      <= p1y;
            end
            WALK: begin
                if (rd_rdy && !at_end) begin
                    err <= err_nxt;
                    if (step_x) x <= sx_neg ? x - COORD_W'(1) : x + COORD_W'(1);
                    if (step_y) y <= sy_neg ? y - COORD_W'(1) : y + COORD_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Returns are accepted in every busy state, so reads and returns overlap freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued    <= '0;
            returned  <= '0;
            reduction <= '0;
        end else if (state == SETUP) begin
            issued    <= '0;
            returned  <= '0;
            reduction <= '0;
        end else begin
            if (rd_val && rd_rdy)
                issued <= issued + CW'(1);
            if (rd_data_val && state != IDLE) begin
                reduction <= reduction + SUM_W'(rd_data);
                returned  <= returned + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_val <= 1'b0;
        else
            wr_val <= rd_data_val && chg && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rd_data_val) begin
            wr_addr <= rd_data_addr;
            wr_data <= sat_sub(rd_data);
        end
    end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Directed and randomized bench for bresenham_line_engine with a latency-modelled
// pixel memory and an integer reference walk of each line.
`timescale 1ns/1ps
module tb_bresenham_line_engine;
    localparam int COORD_W = 9, PIX_W = 8, IMG_W = 512, ADDR_W = 18;
    localparam int THREAD_DELTA = 32, SUM_W = 19;

    logic clk = 1'b0, reset = 1'b1;
    logic req_val = 1'b0, change = 1'b0, resp_rdy = 1'b0;
    logic [COORD_W-1:0] req_point_1_x = '0, req_point_1_y = '0;
    logic [COORD_W-1:0] req_point_2_x = '0, req_point_2_y = '0;
    logic rd_rdy = 1'b0, rd_data_val = 1'b0;
    logic [PIX_W-1:0] rd_data = '0;
    logic [ADDR_W-1:0] rd_data_addr = '0;
    logic req_rdy, rd_val, wr_val, resp_val;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic [SUM_W-1:0] reduction;
    logic [COORD_W:0] pix_count;

    int errors = 0, checks = 0;
    int lat = 1, rdy_mode = 0, const_val = 3, seed = 0, rdy_idx = 0, ncyc = 0;
    bit const_en = 1'b1;
    int seen_addr[$], seen_wa[$], seen_wd[$], exp_addr[$];

    typedef struct {int due; int addr;} ent_t;
    ent_t pend[$];
    bit prev_stall = 1'b0;
    int prev_addr = 0;

    bresenham_line_engine #(.COORD_W(COORD_W), .PIX_W(PIX_W), .IMG_W(IMG_W), .ADDR_W(ADDR_W),
                            .THREAD_DELTA(THREAD_DELTA), .SUM_W(SUM_W)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_point_1_x(req_point_1_x), .req_point_1_y(req_point_1_y),
        .req_point_2_x(req_point_2_x), .req_point_2_y(req_point_2_y),
        .change(change), .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rd_data_val(rd_data_val), .rd_data(rd_data), .rd_data_addr(rd_data_addr),
        .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .reduction(reduction), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mem_val(input int addr);
        if (const_en) return const_val;
        return ((addr * 37) ^ seed) & 255;
    endfunction

    // Pixel memory: returns in order after lat cycles, records reads and writes.
    always @(negedge clk) begin
        ncyc++;
        rd_data_val = 1'b0;
        if (pend.size() > 0 && pend[0].due <= ncyc) begin
            rd_data_val  = 1'b1;
            rd_data_addr = ADDR_W'(pend[0].addr);
            rd_data      = PIX_W'(mem_val(pend[0].addr));
            void'(pend.pop_front());
        end
        case (rdy_mode)
            0:       rd_rdy = 1'b1;
            1:       rd_rdy = (rdy_idx % 3 == 0);
            default: rd_rdy = 1'($urandom_range(0, 1));
        endcase
        rdy_idx++;
        if (reset) prev_stall = 1'b0;
        if (prev_stall && rd_val === 1'b1)
            check("stall_hold_addr", rd_addr, prev_addr);
        prev_stall = (rd_val === 1'b1) && !rd_rdy && !reset;
        prev_addr  = int'(rd_addr);
        if (rd_val === 1'b1 && rd_rdy && !reset) begin
            seen_addr.push_back(int'(rd_addr));
            pend.push_back('{ncyc + lat, int'(rd_addr)});
        end
        if (wr_val === 1'b1) begin
            seen_wa.push_back(int'(wr_addr));
            seen_wd.push_back(int'(wr_data));
        end
    end

    task automatic build_model(input int x1, input int y1, input int x2, input int y2);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_addr.delete();
        x = x1; y = y1;
        dx = (x2 > x1) ? x2 - x1 : x1 - x2;
        dy = -((y2 > y1) ? y2 - y1 : y1 - y2);
        sx = (x1 < x2) ? 1 : -1;
        sy = (y1 < y2) ? 1 : -1;
        err = dx + dy;
        for (int k = 0; k < 2000; k++) begin
            exp_addr.push_back(y * IMG_W + x);
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic start_req(input int x1, input int y1, input int x2, input int y2, input bit chg);
        @(negedge clk);
        check("req_rdy_idle", req_rdy, 1'b1);
        req_point_1_x = COORD_W'(x1); req_point_1_y = COORD_W'(y1);
        req_point_2_x = COORD_W'(x2); req_point_2_y = COORD_W'(y2);
        change = chg; req_val = 1'b1;
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic run_line(input string tag, input int x1, input int y1, input int x2,
                            input int y2, input bit chg, input int l, input int mode);
        int n, red, bad, wbad, dxa, dya, tmo, v;
        lat = l; rdy_mode = mode;
        build_model(x1, y1, x2, y2);
        seen_addr.delete(); seen_wa.delete(); seen_wd.delete();
        start_req(x1, y1, x2, y2, chg);
        @(negedge clk);
        req_point_1_x = ~req_point_1_x; req_point_2_y = ~req_point_2_y;
        change = ~chg; req_val = 1'b1;
        @(negedge clk);
        check({tag, "_busy_req_rdy"}, req_rdy, 1'b0);
        req_val = 1'b0;
        tmo = 0;
        while (resp_val !== 1'b1 && tmo < 5000) begin
            @(negedge clk);
            tmo++;
        end
        check({tag, "_resp_in_time"}, tmo < 5000, 1'b1);
        if (tmo >= 5000) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        @(negedge clk);
        @(negedge clk);
        check({tag, "_resp_held"}, resp_val, 1'b1);
        n = exp_addr.size();
        red = 0; bad = 0; wbad = 0;
        dxa = (x2 > x1) ? x2 - x1 : x1 - x2;
        dya = (y2 > y1) ? y2 - y1 : y1 - y2;
        foreach (exp_addr[i]) begin
            v = mem_val(exp_addr[i]);
            red = (red + v) % (1 << SUM_W);
            if (i < seen_addr.size() && seen_addr[i] != exp_addr[i]) bad++;
            if (chg && i < seen_wa.size() &&
                (seen_wa[i] != exp_addr[i] || seen_wd[i] != ((v > THREAD_DELTA) ? v - THREAD_DELTA : 0)))
                wbad++;
        end
        check({tag, "_pix_count"}, pix_count, n);
        check({tag, "_count_formula"}, pix_count, ((dxa > dya) ? dxa : dya) + 1);
        check({tag, "_reduction"}, reduction, red);
        check({tag, "_num_reads"}, seen_addr.size(), n);
        check({tag, "_addr_mismatches"}, bad, 0);
        check({tag, "_num_writes"}, seen_wa.size(), chg ? n : 0);
        check({tag, "_write_mismatches"}, wbad, 0);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check({tag, "_resp_dropped"}, resp_val, 1'b0);
        check({tag, "_back_idle"}, req_rdy, 1'b1);
    endtask

    initial begin
        int x1, y1, a, b, ax, ay, wsum;
        bit chg;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 1'b1);
        check("rst_rd_val", rd_val, 1'b0);
        check("rst_wr_val", wr_val, 1'b0);
        check("rst_resp_val", resp_val, 1'b0);
        check("rst_reduction", reduction, 0);
        check("rst_pix_count", pix_count, 0);
        reset = 1'b0;

        const_en = 1'b1; const_val = 3;
        run_line("t1", 200, 100, 100, 150, 1'b0, 2, 0);
        check("t1_first_addr", seen_addr[0], 51400);
        check("t1_last_addr", seen_addr[seen_addr.size()-1], 76900);
        check("t1_count_const", pix_count, 101);
        check("t1_reduction_const", reduction, 303);

        const_val = 77;
        run_line("t2", 5, 5, 5, 5, 1'b0, 1, 0);
        check("t2_addr", seen_addr[0], 2565);
        check("t2_count_const", pix_count, 1);
        check("t2_reduction_const", reduction, 77);

        const_val = 20;
        run_line("t3", 10, 0, 10, 7, 1'b1, 3, 0);
        wsum = 0;
        foreach (seen_wd[i]) wsum += seen_wd[i];
        check("t3_writes", seen_wd.size(), 8);
        check("t3_wr_data_saturated", wsum, 0);
        check("t3_reduction_const", reduction, 160);

        const_val = 9;
        run_line("t4", 0, 0, 3, 3, 1'b0, 2, 1);
        check("t4_addr0", seen_addr[0], 0);
        check("t4_addr1", seen_addr[1], 513);
        check("t4_addr2", seen_addr[2], 1026);
        check("t4_addr3", seen_addr[3], 1539);
        check("t4_count_const", pix_count, 4);

        // Mid-walk abort followed by a clean restart
        const_en = 1'b0; seed = 91; lat = 3; rdy_mode = 0;
        start_req(0, 10, 79, 10, 1'b1);
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_rd_val", rd_val, 1'b0);
        check("abort_wr_val", wr_val, 1'b0);
        check("abort_resp_val", resp_val, 1'b0);
        check("abort_req_rdy", req_rdy, 1'b1);
        check("abort_reduction", reduction, 0);
        check("abort_pix_count", pix_count, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_wa.delete(); seen_wd.delete(); seen_addr.delete();
        repeat (10) @(negedge clk);
        check("abort_no_late_writes", seen_wa.size(), 0);
        check("abort_no_reads", seen_addr.size(), 0);
        run_line("restart", 1, 1, 4, 1, 1'b0, 2, 0);
        check("restart_addr0", seen_addr[0], 513);
        check("restart_addr3", seen_addr[3], 516);
        check("restart_count_const", pix_count, 4);

        // All eight octants: bit0 x direction, bit1 y direction, bit2 steep
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 60);
            b = $urandom_range(0, a);
            ax = i[2] ? b : a;
            ay = i[2] ? a : b;
            x1 = $urandom_range(64, 447);
            y1 = $urandom_range(64, 447);
            seed = $urandom_range(0, 255);
            chg = 1'($urandom_range(0, 1));
            run_line($sformatf("oct%0d", i), x1, y1, i[0] ? x1 - ax : x1 + ax,
                     i[1] ? y1 - ay : y1 + ay, chg, $urandom_range(1, 4), $urandom_range(0, 2));
        end
        for (int i = 0; i < 2; i++) begin
            seed = $urandom_range(0, 255);
            run_line($sformatf("long%0d", i), $urandom_range(0, 511), $urandom_range(0, 511),
                     $urandom_range(0, 511), $urandom_range(0, 511), 1'b1, $urandom_range(1, 4), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
